// File: rtl/x4_spi_pkg.sv
// Shared types and constants for the X4 byte-level SPI master.
package x4_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        WAIT_REL
    } state_t;

    typedef enum logic {
        TX,
        RX
    } mode_t;

    localparam int BYTE_BITS       = 8;
    localparam int HALF_PERIODS    = 16;
    localparam int HALF_W          = $clog2(HALF_PERIODS);
    localparam int DEFAULT_CLK_DIV = 4;

    // True on the final SCLK half-period of a byte (the 8th falling edge).
    function automatic logic is_last_half(input logic [HALF_W-1:0] half);
        return half == HALF_W'(HALF_PERIODS - 1);
    endfunction

endpackage

// File: rtl/x4_spi_byte_master_if.sv
// Request/response handshake with the register sequencer plus the SPI pins.
interface x4_spi_byte_master_if
    import x4_spi_pkg::*;
;
    logic                 tx_en;
    logic                 rx_en;
    logic [BYTE_BITS-1:0] tx_data;
    logic                 tx_done;
    logic                 rx_done;
    logic [BYTE_BITS-1:0] rx_data;
    logic                 busy;
    logic                 spi_sclk;
    logic                 spi_mosi;
    logic                 spi_miso;

    // The byte engine side.
    modport master (
        input  tx_en, rx_en, tx_data, spi_miso,
        output tx_done, rx_done, rx_data, busy, spi_sclk, spi_mosi
    );

    // The sequencer / pin side.
    modport slave (
        output tx_en, rx_en, tx_data, spi_miso,
        input  tx_done, rx_done, rx_data, busy, spi_sclk, spi_mosi
    );

endinterface

// File: rtl/x4_spi_halfbit_timer.sv
// Counts CLK_DIV clk cycles per SCLK half-period and flags the last one.
module x4_spi_halfbit_timer
    import x4_spi_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [7:0] LP_TERMINAL = 8'(CLK_DIV - 1);

    logic [7:0] r_count;

    // Tick on the terminal count; held off while the counter is being cleared.
    assign o_tick = !i_clear && (r_count == LP_TERMINAL);

    // Free-running half-period counter, restarts after each tick or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/x4_spi_byte_master.sv
// SPI mode 0, MSB-first byte engine: one byte per tx_en/rx_en request.
module x4_spi_byte_master
    import x4_spi_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input logic                   clk,
    input logic                   rst,
    x4_spi_byte_master_if.master  io_spi
);

    state_t                 r_state;
    mode_t                  r_mode;
    logic [BYTE_BITS-2:0]   r_shift_out;   // bits still to present; bit 7 goes straight to MOSI
    logic [BYTE_BITS-1:0]   r_shift_in;
    logic [HALF_W-1:0]      r_half;
    logic                   r_sclk;
    logic                   r_mosi;
    logic                   r_busy;
    logic                   r_tx_done;
    logic                   r_rx_done;
    logic [BYTE_BITS-1:0]   r_rx_data;
    logic                   w_tick;
    logic                   w_clear;

    // The half-period counter only runs while shifting, so it starts at 0 on entry.
    assign w_clear = (r_state != SHIFT);

    x4_spi_halfbit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    assign io_spi.tx_done  = r_tx_done;
    assign io_spi.rx_done  = r_rx_done;
    assign io_spi.rx_data  = r_rx_data;
    assign io_spi.busy     = r_busy;
    assign io_spi.spi_sclk = r_sclk;
    assign io_spi.spi_mosi = r_mosi;

    // Byte FSM with shift registers and registered pin/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= TX;
            r_shift_out <= '0;
            r_shift_in  <= '0;
            r_half      <= '0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_tx_done   <= 1'b0;
            r_rx_done   <= 1'b0;
            r_rx_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_spi.tx_en || io_spi.rx_en) begin
                        r_state    <= SHIFT;
                        r_busy     <= 1'b1;
                        r_sclk     <= 1'b0;
                        r_half     <= '0;
                        r_shift_in <= '0;
                        // TX has priority when both requests arrive together.
                        if (io_spi.tx_en) begin
                            r_mode      <= TX;
                            r_mosi      <= io_spi.tx_data[BYTE_BITS-1];
                            r_shift_out <= io_spi.tx_data[BYTE_BITS-2:0];
                        end else begin
                            r_mode      <= RX;
                            r_mosi      <= 1'b0;
                            r_shift_out <= '0;
                        end
                    end
                end

                SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            // Rising edge: sample MISO.
                            r_shift_in <= {r_shift_in[BYTE_BITS-2:0], io_spi.spi_miso};
                        end else begin
                            // Falling edge: present the next bit; the line parks low after the last.
                            r_shift_out <= {r_shift_out[BYTE_BITS-3:0], 1'b0};
                            r_mosi      <= is_last_half(r_half) ? 1'b0 : r_shift_out[BYTE_BITS-2];
                        end
                        if (is_last_half(r_half)) begin
                            r_state   <= DONE;
                            r_tx_done <= (r_mode == TX);
                            r_rx_done <= (r_mode == RX);
                            if (r_mode == RX) begin
                                r_rx_data <= r_shift_in;
                            end
                        end else begin
                            r_half <= r_half + 1'b1;
                        end
                    end
                end

                DONE: begin
                    r_tx_done <= 1'b0;
                    r_rx_done <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= WAIT_REL;
                end

                WAIT_REL: begin
                    // A request held across done must not start a second byte.
                    if (!(io_spi.tx_en || io_spi.rx_en)) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x4_spi_byte_master.sv
// Directed bench for x4_spi_byte_master at CLK_DIV=4 (dut_a) and CLK_DIV=1 (dut_b).
module tb_x4_spi_byte_master;

    logic clk = 1'b0;
    logic rst;
    logic sel;                 // 0: drive/observe dut_a, 1: dut_b

    always #5 clk = ~clk;

    x4_spi_byte_master_if ifa ();
    x4_spi_byte_master_if ifb ();

    x4_spi_byte_master #(.CLK_DIV(4)) dut_a (.clk(clk), .rst(rst), .io_spi(ifa));
    x4_spi_byte_master #(.CLK_DIV(1)) dut_b (.clk(clk), .rst(rst), .io_spi(ifb));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [7:0] exp_rx;

    // Observed signals of the selected DUT.
    wire       m_sclk    = sel ? ifb.spi_sclk : ifa.spi_sclk;
    wire       m_mosi    = sel ? ifb.spi_mosi : ifa.spi_mosi;
    wire       m_busy    = sel ? ifb.busy     : ifa.busy;
    wire       m_tx_done = sel ? ifb.tx_done  : ifa.tx_done;
    wire       m_rx_done = sel ? ifb.rx_done  : ifa.rx_done;
    wire [7:0] m_rx_data = sel ? ifb.rx_data  : ifa.rx_data;

    // MISO slave model: bit7 before the first rising edge, next bit on each falling edge.
    int         n_falls = 0;
    int         miso_base = 0;
    logic [7:0] miso_byte = 8'h00;
    logic       miso_bit;

    always @(negedge m_sclk) n_falls++;

    always_comb begin
        int idx;
        miso_bit = 1'b0;
        idx = 7 - (n_falls - miso_base);
        if (idx >= 0 && idx <= 7) miso_bit = miso_byte[idx];
    end

    assign ifa.spi_miso = miso_bit;
    assign ifb.spi_miso = miso_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic tx, input logic rx, input logic [7:0] d);
        if (sel) begin
            ifb.tx_en = tx; ifb.rx_en = rx; ifb.tx_data = d;
        end else begin
            ifa.tx_en = tx; ifa.rx_en = rx; ifa.tx_data = d;
        end
    endtask

    // One full byte: raise request at a negedge, accept on the next posedge (cycle N),
    // then sample every negedge (k = cycle offset from N).
    task automatic run_byte(input string tag, input logic do_tx, input logic do_rx,
                            input logic [7:0] txd, input logic [7:0] mb,
                            input int div, input int hold);
        logic [7:0] exp_mosi;
        logic [7:0] exp_rxd;
        logic [7:0] mosi_bits = 8'h00;
        logic       prev_sclk = 1'b0;
        logic       other_done = 1'b0;
        logic       busy_ok = 1'b1;
        logic       spacing_ok = 1'b1;
        logic       hold_ok = 1'b1;
        logic       my_done;
        int         rises = 0;
        int         high = 0;
        int         last_rise = -1;
        int         done_k = -1;
        exp_mosi  = do_tx ? txd : 8'h00;
        exp_rxd   = do_tx ? exp_rx : mb;
        miso_byte = mb;
        miso_base = n_falls;
        set_req(do_tx, do_rx, txd);
        @(posedge clk);
        #1 set_req(do_tx, do_rx, ~txd);          // later tx_data changes must be ignored
        for (int k = 1; k <= 16 * div + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, "_busy_on_accept"}, {31'd0, m_busy}, 32'd1);
                chk({tag, "_first_mosi"}, {31'd0, m_mosi}, {31'd0, exp_mosi[7]});
            end
            if (m_sclk && !prev_sclk) begin
                mosi_bits = {mosi_bits[6:0], m_mosi};
                if (last_rise >= 0 && (k - last_rise) != 2 * div) spacing_ok = 1'b0;
                last_rise = k;
                rises++;
            end
            if (m_sclk) high++;
            prev_sclk = m_sclk;
            if (do_tx ? m_rx_done : m_tx_done) other_done = 1'b1;
            if (!m_busy) busy_ok = 1'b0;
            my_done = do_tx ? m_tx_done : m_rx_done;
            if (my_done) begin
                done_k = k;
                chk({tag, "_rx_data"}, {24'd0, m_rx_data}, {24'd0, exp_rxd});
                chk({tag, "_sclk_low_at_done"}, {31'd0, m_sclk}, 32'd0);
                break;
            end
        end
        chk({tag, "_done_cycle"}, done_k, 1 + 16 * div);
        chk({tag, "_mosi_bits"}, {24'd0, mosi_bits}, {24'd0, exp_mosi});
        chk({tag, "_sclk_rises"}, rises, 8);
        chk({tag, "_sclk_high_cycles"}, high, 8 * div);
        chk({tag, "_sclk_period_ok"}, {31'd0, spacing_ok}, 32'd1);
        chk({tag, "_other_done_quiet"}, {31'd0, other_done}, 32'd0);
        chk({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        exp_rx = exp_rxd;
        // Cycle after done: pulse gone, busy low, request still held.
        @(negedge clk);
        chk({tag, "_done_pulse_1cyc"}, {30'd0, m_tx_done, m_rx_done}, 32'd0);
        chk({tag, "_busy_after_done"}, {31'd0, m_busy}, 32'd0);
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            if (m_busy || m_sclk || m_tx_done || m_rx_done) hold_ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_no_restart_while_held"}, {31'd0, hold_ok}, 32'd1);
        set_req(1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        chk({tag, "_idle_after_release"}, {31'd0, m_busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        ifa.tx_en = 1'b0; ifa.rx_en = 1'b0; ifa.tx_data = 8'h00;
        ifb.tx_en = 1'b0; ifb.rx_en = 1'b0; ifb.tx_data = 8'h00;
        exp_rx = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, ifa.busy}, 32'd0);
        chk("reset_sclk", {31'd0, ifa.spi_sclk}, 32'd0);
        chk("reset_mosi", {31'd0, ifa.spi_mosi}, 32'd0);
        chk("reset_dones", {30'd0, ifa.tx_done, ifa.rx_done}, 32'd0);
        chk("reset_rx_data", {24'd0, ifa.rx_data}, 32'd0);
        chk("reset_b_sclk_busy", {30'd0, ifb.spi_sclk, ifb.busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CLK_DIV=4 transfers
        run_byte("tx_a5",  1'b1, 1'b0, 8'hA5, 8'hFF, 4, 0);
        run_byte("rx_3c",  1'b0, 1'b1, 8'h00, 8'h3C, 4, 0);
        run_byte("both_5a", 1'b1, 1'b1, 8'h5A, 8'hC3, 4, 0);
        run_byte("held",   1'b1, 1'b0, 8'h96, 8'h00, 4, 20);
        run_byte("after_hold", 1'b1, 1'b0, 8'h01, 8'h00, 4, 0);

        // Reset during half-period 7 (SCLK high after the 4th rising edge).
        miso_byte = 8'h00;
        miso_base = n_falls;
        set_req(1'b1, 1'b0, 8'hC3);
        @(posedge clk);
        repeat (30) @(negedge clk);
        chk("midrst_sclk_high_before", {31'd0, m_sclk}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sclk_async", {31'd0, m_sclk}, 32'd0);
        chk("midrst_busy_async", {31'd0, m_busy}, 32'd0);
        chk("midrst_no_done", {30'd0, m_tx_done, m_rx_done}, 32'd0);
        chk("midrst_rx_data_clr", {24'd0, m_rx_data}, 32'd0);
        exp_rx = 8'h00;
        set_req(1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_idle_after", {29'd0, m_busy, m_tx_done, m_rx_done}, 32'd0);
        run_byte("post_rst_rx", 1'b0, 1'b1, 8'h00, 8'hE7, 4, 0);

        // CLK_DIV=1 transfers on dut_b
        sel = 1'b1;
        exp_rx = 8'h00;
        repeat (2) @(negedge clk);
        run_byte("div1_tx_ff", 1'b1, 1'b0, 8'hFF, 8'h00, 1, 0);
        run_byte("div1_rx_81", 1'b0, 1'b1, 8'h00, 8'h81, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
